sram_controller: RTL and testbench
==================================

SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter WAIT_CYCLES, default 4: idle cycles after the second half-access, legal range 1..15.
REQ-002 Parameter BASE_ADDR, default 1024: byte address mapped to SRAM word 0.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 wr_en  input  1  write request from the MEM stage.
REQ-006 rd_en  input  1  read request from the MEM stage.
REQ-007 address  input  32  byte address, word-aligned.
REQ-008 wdata  input  32  write data.
REQ-009 rdata  output  32  read data, registered.
REQ-010 ready  output  1  low = pipeline must freeze; high = access complete or no access pending.
REQ-011 SRAM_DQ  inout  16  SRAM data bus.
REQ-012 SRAM_ADDR  output  18  SRAM half-word address, registered.
REQ-013 SRAM_WE_N  output  1  write enable, active-low.
REQ-014 SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  output  1 each  tied to 0.

Function
REQ-015 States: IDLE, LOW, HIGH, WAIT, DONE.
REQ-016 Word index: idx = (address - BASE_ADDR)[18:2], 17 bits; address bits [1:0] and bits above 18 are ignored.
REQ-017 IDLE: if wr_en or rd_en, latch idx, wdata and op, then go to LOW; otherwise stay in IDLE.
REQ-018 Write has priority when wr_en and rd_en are both high; the access is treated as a write.
REQ-019 LOW (1 cycle): SRAM_ADDR = {idx,0}; a write drives SRAM_DQ = wdata[15:0] with SRAM_WE_N = 0; a read samples SRAM_DQ into rdata[15:0] at the cycle end.
REQ-020 HIGH (1 cycle): SRAM_ADDR = {idx,1}; a write drives wdata[31:16] with SRAM_WE_N = 0; a read samples into rdata[31:16].
REQ-021 WAIT: a 4-bit down-counter is loaded with WAIT_CYCLES on entry; the state exits to DONE after exactly WAIT_CYCLES cycles; SRAM_WE_N = 1 and SRAM_DQ is high-Z throughout.
REQ-022 DONE (1 cycle): ready = 1, then unconditionally return to IDLE.
REQ-023 ready is combinational: 1 in DONE, 1 in IDLE with no request, 0 otherwise.
REQ-024 Latency: for a request first seen in IDLE at cycle 0, ready is low for cycles 0..2+WAIT_CYCLES and high at cycle 3+WAIT_CYCLES (cycle 7 at default).
REQ-025 A request still asserted in IDLE after DONE starts a new access; there is no request queue.
REQ-026 SRAM_DQ is driven only in LOW and HIGH of a write; it is high-Z at all other times.
REQ-027 rdata holds its value until the next read overwrites it; writes leave rdata unchanged.
REQ-028 Request inputs are ignored outside IDLE; latched idx, wdata and op are stable for the whole access.

Reset
REQ-029 rst low forces, asynchronously: state = IDLE, rdata = 0, SRAM_ADDR = 0, SRAM_WE_N = 1, SRAM_DQ high-Z, wait counter = 0.
REQ-030 Reset during any state aborts the access immediately; a partial write may leave the low half-word written; the first access after reset release starts from IDLE.

Structure
REQ-031 Shared package sram_ctrl_pkg holds the state enum, the SRAM address width (18), the data widths (16/32) and the default WAIT_CYCLES and BASE_ADDR.
REQ-032 No sub-module: the FSM, wait counter and tri-state driver are implemented inline.

Verification
REQ-033 Write test: wr_en, address = 1024, wdata = 0xDEADBEEF -> SRAM word 0 = 0xBEEF, word 1 = 0xDEAD; ready low for 7 cycles, then high for 1.
REQ-034 Read-back test: after REQ-033, rd_en at address 1024 -> rdata = 0xDEADBEEF when ready rises at cycle 7.
REQ-035 Simultaneous request: wr_en = rd_en = 1, address = 1028, wdata = 0x12345678 -> write performed (SRAM words 2/3 = 0x5678/0x1234); rdata unchanged.
REQ-036 Back-to-back requests: rd_en held high across two accesses -> two complete 8-cycle sequences; ready high exactly once per access; SRAM_DQ high-Z throughout.
REQ-037 Reset mid-access: assert rst during HIGH of a write -> SRAM_WE_N = 1 and SRAM_DQ high-Z in the same cycle; state = IDLE; ready = 1 once rst is released with no request.
REQ-038 Parameter test: WAIT_CYCLES = 1 -> ready high at cycle 4 after the request.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the 32-bit to 16-bit SRAM bridge.
// Holds the FSM state enum, bus widths, defaults and the word-index helper.
package sram_ctrl_pkg;

    localparam int SRAM_AW = 18;
    localparam int HALF_W  = 16;
    localparam int WORD_W  = 32;
    localparam int IDX_W   = 17;
    localparam int CNT_W   = 4;

    localparam int              DEF_WAIT_CYCLES = 4;
    localparam logic [WORD_W-1:0] DEF_BASE_ADDR = 32'd1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_WAIT,
        ST_DONE
    } state_e;

    // Byte offset from the mapped base, reduced to the SRAM word index.
    function automatic logic [IDX_W-1:0] word_idx(
        input logic [WORD_W-1:0] addr,
        input logic [WORD_W-1:0] base
    );
        logic [WORD_W-1:0] off;
        off = addr - base;
        return off[18:2];
    endfunction

endpackage

// File: rtl/sram_controller.sv
// MEM-stage bridge: one 32-bit access becomes two 16-bit SRAM cycles plus
// a programmable idle gap; ready freezes the pipeline until it finishes.
//
// Ports:
//   clk, rst (async, active-low)
//   wr_en, rd_en, address[31:0], wdata[31:0]  - request from MEM stage
//   rdata[31:0], ready                         - result / stall
//   SRAM_DQ[15:0] (inout), SRAM_ADDR[17:0], SRAM_WE_N,
//   SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N (tied low)
module sram_controller
    import sram_ctrl_pkg::*;
#(
    parameter int                WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter logic [WORD_W-1:0] BASE_ADDR   = DEF_BASE_ADDR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [WORD_W-1:0]  address,
    input  logic [WORD_W-1:0]  wdata,
    output logic [WORD_W-1:0]  rdata,
    output logic               ready,
    inout  wire  [HALF_W-1:0]  SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WORD_W-1:0]  wdata_q, wdata_d;
    logic               is_wr_q, is_wr_d;
    logic [WORD_W-1:0]  rdata_q, rdata_d;
    logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;

    logic               req;
    logic [IDX_W-1:0]   req_idx;
    logic               dq_oe;
    logic [HALF_W-1:0]  dq_out;

    assign req     = wr_en | rd_en;
    assign req_idx = word_idx(address, BASE_ADDR);

    // State register and datapath flops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            wdata_q     <= '0;
            is_wr_q     <= 1'b0;
            rdata_q     <= '0;
            sram_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            is_wr_q     <= is_wr_d;
            rdata_q     <= rdata_d;
            sram_addr_q <= sram_addr_d;
        end
    end

    // Next-state and next-datapath logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        is_wr_d     = is_wr_q;
        rdata_d     = rdata_q;
        sram_addr_d = sram_addr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    idx_d       = req_idx;
                    wdata_d     = wdata;
                    // wr_en wins when both are asserted
                    is_wr_d     = wr_en;
                    // Address is registered, so set it up for LOW now
                    sram_addr_d = {req_idx, 1'b0};
                    state_d     = ST_LOW;
                end
            end
            ST_LOW: begin
                if (!is_wr_q) begin
                    rdata_d[HALF_W-1:0] = SRAM_DQ;
                end
                sram_addr_d = {idx_q, 1'b1};
                state_d     = ST_HIGH;
            end
            ST_HIGH: begin
                if (!is_wr_q) begin
                    rdata_d[WORD_W-1:HALF_W] = SRAM_DQ;
                end
                cnt_d   = CNT_W'(WAIT_CYCLES);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                // Last idle cycle is the one entered with count 1
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        ready  = 1'b0;
        dq_oe  = 1'b0;
        dq_out = wdata_q[HALF_W-1:0];
        unique case (state_q)
            ST_IDLE: ready = !req;
            ST_LOW:  dq_oe = is_wr_q;
            ST_HIGH: begin
                dq_oe  = is_wr_q;
                dq_out = wdata_q[WORD_W-1:HALF_W];
            end
            ST_DONE: ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    assign SRAM_DQ   = dq_oe ? dq_out : {HALF_W{1'bz}};
    assign SRAM_WE_N = !dq_oe;
    assign SRAM_ADDR = sram_addr_q;
    assign rdata     = rdata_q;

    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: behavioural SRAM on the DQ bus and a
// scoreboard of expected latency/read data per access.
module tb_sram_controller;

    logic        clk;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, wdata;
    logic [31:0] rdata;
    logic        ready;
    wire  [15:0] dq;
    logic [17:0] sram_addr;
    logic        we_n, ub_n, lb_n, ce_n, oe_n;

    logic        wr1;
    logic [31:0] rdata1;
    logic        ready1;
    wire  [15:0] dq1;
    logic [17:0] sram_addr1;
    logic        we1_n, ub1_n, lb1_n, ce1_n, oe1_n;

    logic [15:0] mem [64];
    logic [15:0] mem_out;

    typedef struct {
        int          lat;
        logic [31:0] rd;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    sram_controller dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .address   (address),
        .wdata     (wdata),
        .rdata     (rdata),
        .ready     (ready),
        .SRAM_DQ   (dq),
        .SRAM_ADDR (sram_addr),
        .SRAM_WE_N (we_n),
        .SRAM_UB_N (ub_n),
        .SRAM_LB_N (lb_n),
        .SRAM_CE_N (ce_n),
        .SRAM_OE_N (oe_n)
    );

    sram_controller #(.WAIT_CYCLES(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr1),
        .rd_en     (1'b0),
        .address   (32'd1024),
        .wdata     (32'hA5A5_5A5A),
        .rdata     (rdata1),
        .ready     (ready1),
        .SRAM_DQ   (dq1),
        .SRAM_ADDR (sram_addr1),
        .SRAM_WE_N (we1_n),
        .SRAM_UB_N (ub1_n),
        .SRAM_LB_N (lb1_n),
        .SRAM_CE_N (ce1_n),
        .SRAM_OE_N (oe1_n)
    );

    // SRAM model: drives the bus whenever not being written
    assign mem_out = mem[sram_addr[5:0]];
    assign dq      = we_n ? mem_out : 16'hzzzz;
    assign dq1     = we1_n ? 16'h0000 : 16'hzzzz;

    always @(posedge clk) begin
        if (!we_n) mem[sram_addr[5:0]] <= dq;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One access; expected latency/rdata go to the scoreboard up front
    task automatic run_access(input string tag, input logic wr,
                              input logic rd, input logic [31:0] addr,
                              input logic [31:0] data, input int exp_lat,
                              input logic [31:0] exp_rd);
        int   n;
        exp_t e;
        sb.push_back('{lat: exp_lat, rd: exp_rd});
        @(negedge clk);
        wr_en   = wr;
        rd_en   = rd;
        address = addr;
        wdata   = data;
        #1;
        n = 0;
        while (!ready && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        e = sb.pop_front();
        check({tag, "_lat"}, n, e.lat);
        check({tag, "_rdata"}, rdata, e.rd);
    endtask

    initial begin
        int   ready_cnt, bus_bad, we_bad, start, n;
        exp_t e;

        rst     = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        address = '0;
        wdata   = '0;
        wr1     = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", ready, 1);
        check("rst_rdata", rdata, 0);
        check("rst_addr", sram_addr, 0);
        check("rst_we_n", we_n, 1);
        check("ties", {ub_n, lb_n, ce_n, oe_n}, 0);
        rst = 1'b1;

        run_access("wr0", 1, 0, 32'd1024, 32'hDEAD_BEEF, 7, 32'h0);
        check("wr0_mem0", mem[0], 16'hBEEF);
        check("wr0_mem1", mem[1], 16'hDEAD);

        run_access("rd0", 0, 1, 32'd1024, 32'h0, 7, 32'hDEAD_BEEF);

        run_access("both", 1, 1, 32'd1028, 32'h1234_5678, 7, 32'hDEAD_BEEF);
        check("both_mem2", mem[2], 16'h5678);
        check("both_mem3", mem[3], 16'h1234);

        // Back-to-back reads with rd_en held across both accesses
        sb.push_back('{lat: 7, rd: 32'h1234_5678});
        sb.push_back('{lat: 7, rd: 32'h1234_5678});
        ready_cnt = 0;
        bus_bad   = 0;
        we_bad    = 0;
        start     = 0;
        @(negedge clk);
        rd_en   = 1'b1;
        address = 32'd1028;
        wdata   = 32'hFFFF_FFFF;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (we_n !== 1'b1) we_bad++;
            if (dq !== mem_out) bus_bad++;
            if (ready) begin
                ready_cnt++;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("b2b_lat", c - start, e.lat);
                    check("b2b_rdata", rdata, e.rd);
                end
                start = c + 1;
            end
        end
        rd_en = 1'b0;
        check("b2b_ready_cnt", ready_cnt, 2);
        check("b2b_we_n", we_bad, 0);
        check("b2b_dq_hiz", bus_bad, 0);
        check("b2b_sb_left", sb.size(), 0);
        sb.delete();

        // Reset during the HIGH half of a write
        @(negedge clk);
        wr_en   = 1'b1;
        address = 32'd1032;
        wdata   = 32'hCAFE_F00D;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("mid_we_low", we_n, 0);
        rst   = 1'b0;
        wr_en = 1'b0;
        #1;
        check("mid_we_n", we_n, 1);
        check("mid_dq_hiz", dq, mem_out);
        check("mid_rdata", rdata, 0);
        check("mid_addr", sram_addr, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_ready", ready, 1);
        check("mid_mem4", mem[4], 16'hF00D);

        run_access("rd1", 0, 1, 32'd1024, 32'h0, 7, 32'hDEAD_BEEF);

        // WAIT_CYCLES = 1 instance
        sb.push_back('{lat: 4, rd: 32'h0});
        @(negedge clk);
        wr1 = 1'b1;
        #1;
        n = 0;
        while (!ready1 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        wr1 = 1'b0;
        e = sb.pop_front();
        check("w1_lat", n, e.lat);
        check("w1_rdata", rdata1, e.rd);
        check("w1_addr", sram_addr1, 18'd1);
        check("w1_ties", {ub1_n, lb1_n, ce1_n, oe1_n}, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
